md_sched: RTL and testbench

- Sequencing controller for the multiply/divide resource in the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo from E stage and models the fixed multi-cycle latency with a busy counter.
- Owns the HI/LO registers and drives the D-stage stall whenever an MD-class instruction would collide with a pending operation.

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_calc.sv | 46 ++++
 rtl/md_sched.sv | 133 +++++++++++++
 tb/tb_md_sched.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings, FSM states and sizing constants for the multiply/divide sequencer.
package md_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 4;

  typedef enum logic [3:0] {
    MD_MULT  = 4'b0000,
    MD_MULTU = 4'b0001,
    MD_DIV   = 4'b0010,
    MD_DIVU  = 4'b0011,
    MD_MFHI  = 4'b0100,
    MD_MFLO  = 4'b0101,
    MD_MTHI  = 4'b0110,
    MD_MTLO  = 4'b0111
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: result packed as {hi, lo}, plus divide-by-zero flag.
module md_calc import md_pkg::*; (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [63:0] res,
  output logic        div0
);

  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic signed [31:0] sa;
  logic signed [31:0] sb;

  // Result select; INT_MIN / -1 is pinned so the quotient never overflows the divider.
  always_comb begin
    sa   = $signed(a);
    sb   = $signed(b);
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    res  = 64'd0;
    div0 = 1'b0;
    case (op)
      MD_MULT:  res = sa64 * sb64;
      MD_MULTU: res = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          res = {32'd0, 32'h8000_0000};
        end else begin
          res = {sa % sb, sa / sb};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else begin
          res = {a % b, a / b};
        end
      end
      default: res = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: busy counter, HI/LO ownership and D-stage stall.
// Optional MDU_CANCEL_EN adds a cancel input that aborts a pending operation without commit.
module md_sched import md_pkg::*; #(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        E_start,
  input  logic [3:0]  E_MDCtrl,
  input  logic        E_MD,
  input  logic        D_MD,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] MDout,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        stall
);

  md_state_e        state_r, state_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic [31:0]      hi_r, hi_nx, lo_r, lo_nx;
  logic [63:0]      pend_r, pend_nx;
  logic             pend_ok_r, pend_ok_nx;
  logic [63:0]      calc_res_s;
  logic             calc_div0_s;
  logic             cancel_s;
  logic             is_div_s;

  md_calc u_calc (
    .a    (A),
    .b    (B),
    .op   (E_MDCtrl),
    .res  (calc_res_s),
    .div0 (calc_div0_s)
  );

`ifdef MDU_CANCEL_EN
  assign cancel_s = cancel;
`else
  assign cancel_s = 1'b0;
`endif

  assign is_div_s = (E_MDCtrl == MD_DIV) || (E_MDCtrl == MD_DIVU);

  // Next-state, counter and HI/LO update; a cancel overrides everything on its edge.
  always_comb begin
    state_nx   = state_r;
    cnt_nx     = cnt_r;
    hi_nx      = hi_r;
    lo_nx      = lo_r;
    pend_nx    = pend_r;
    pend_ok_nx = pend_ok_r;
    if (cancel_s) begin
      state_nx = IDLE;
      cnt_nx   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (E_start) begin
            pend_nx    = calc_res_s;
            pend_ok_nx = ~calc_div0_s;
            cnt_nx     = is_div_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_nx   = BUSY;
          end else if (E_MD && (E_MDCtrl == MD_MTHI)) begin
            hi_nx = A;
          end else if (E_MD && (E_MDCtrl == MD_MTLO)) begin
            lo_nx = A;
          end else begin
            state_nx = IDLE;
          end
        end
        BUSY: begin
          if (cnt_r == CNT_W'(1'b1)) begin
            if (pend_ok_r) begin
              hi_nx = pend_r[63:32];
              lo_nx = pend_r[31:0];
            end else begin
              hi_nx = hi_r;
            end
            cnt_nx   = {CNT_W{1'b0}};
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt_r - CNT_W'(1'b1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and architectural register update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_r    <= 64'd0;
      pend_ok_r <= 1'b0;
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      hi_r      <= hi_nx;
      lo_r      <= lo_nx;
      pend_r    <= pend_nx;
      pend_ok_r <= pend_ok_nx;
    end
  end

  // Move-from read path.
  always_comb begin
    case (E_MDCtrl)
      MD_MFHI: MDout = hi_r;
      MD_MFLO: MDout = lo_r;
      default: MDout = 32'd0;
    endcase
  end

  assign HI    = hi_r;
  assign LO    = lo_r;
  assign busy  = (state_r == BUSY);
  assign stall = D_MD & (E_start | busy);

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected HI/LO/latency queued at issue, checked when busy drops.
module tb_md_sched;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_start;
  logic [3:0]  E_MDCtrl;
  logic        E_MD;
  logic        D_MD;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] MDout;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        stall;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  md_sched dut (
    .clk      (clk),
    .reset    (reset),
`ifdef MDU_CANCEL_EN
    .cancel   (cancel),
`endif
    .E_start  (E_start),
    .E_MDCtrl (E_MDCtrl),
    .E_MD     (E_MD),
    .D_MD     (D_MD),
    .A        (A),
    .B        (B),
    .MDout    (MDout),
    .HI       (HI),
    .LO       (LO),
    .busy     (busy),
    .stall    (stall)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one start, track busy length and stall, then score against the queued expectation.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd, input logic inj,
                        input logic [31:0] ehi, input logic [31:0] elo, input int en);
    exp_t e;
    int   n;
    e.hi = ehi; e.lo = elo; e.n = en;
    sb_q.push_back(e);
    @(posedge clk); #1;
    E_start = 1'b1; E_MD = 1'b1; E_MDCtrl = op; A = a; B = b; D_MD = dmd;
    @(negedge clk);
    check_eq("stall_start", {63'd0, stall}, {63'd0, dmd});
    @(posedge clk); #1;
    E_start = 1'b0; E_MD = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      check_eq("stall_busy", {63'd0, stall}, {63'd0, dmd});
      if (inj && n == 2) begin
        E_MD = 1'b1; E_MDCtrl = MD_MTLO; A = 32'h0000_ABCD;
      end else if (inj && n == 3) begin
        E_MD = 1'b0;
      end
    end
    check_eq("stall_idle", {63'd0, stall}, 64'd0);
    check_eq("sb_size", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("busy_len", 64'(n), 64'(e.n));
      check_eq("hi", {32'd0, HI}, {32'd0, e.hi});
      check_eq("lo", {32'd0, LO}, {32'd0, e.lo});
    end
    D_MD = 1'b0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    E_MD = 1'b1; E_MDCtrl = op; A = a;
    @(posedge clk); #1;
    E_MD = 1'b0;
  endtask

  task automatic mf_check(input string tag, input logic [3:0] op, input logic [31:0] exp);
    @(posedge clk); #1;
    E_MD = 1'b1; E_MDCtrl = op;
    @(negedge clk);
    check_eq(tag, {32'd0, MDout}, {32'd0, exp});
    E_MD = 1'b0; E_MDCtrl = MD_MULT;
  endtask

  // Start a div and step to the busy cycle where the counter reads 3.
  task automatic start_div_to_cnt3();
    @(posedge clk); #1;
    E_start = 1'b1; E_MD = 1'b1; E_MDCtrl = MD_DIV; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    E_start = 1'b0; E_MD = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    check_eq("busy_at_cnt3", {63'd0, busy}, 64'd1);
  endtask

  initial begin
    reset = 1'b1; E_start = 1'b0; E_MDCtrl = MD_MFHI; E_MD = 1'b0; D_MD = 1'b1;
    A = 32'd0; B = 32'd0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_hi", {32'd0, HI}, 64'd0);
    check_eq("rst_lo", {32'd0, LO}, 64'd0);
    check_eq("rst_mdout", {32'd0, MDout}, 64'd0);
    check_eq("rst_stall", {63'd0, stall}, 64'd0);
    reset = 1'b0; D_MD = 1'b0; E_MDCtrl = MD_MULT;

    run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    mf_check("mfhi", MD_MFHI, 32'hFFFF_FFFF);
    run_op(MD_DIVU,  32'd7, 32'd2, 1'b0, 1'b0, 32'd1, 32'd3, 10);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op(MD_DIVU,  32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd1, 32'h7FFF_FFFC, 10);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    run_op(MD_MULT,  32'h8000_0000, 32'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 5);

    mt(MD_MTHI, 32'h1234_5678);
    check_eq("mthi", {32'd0, HI}, {32'd0, 32'h1234_5678});
    mt(MD_MTLO, 32'h55AA_55AA);
    check_eq("mtlo", {32'd0, LO}, {32'd0, 32'h55AA_55AA});
    run_op(MD_DIV, 32'd5, 32'd0, 1'b1, 1'b0, 32'h1234_5678, 32'h55AA_55AA, 10);

    run_op(MD_MULT, 32'd3, 32'd4, 1'b1, 1'b1, 32'd0, 32'h0000_000C, 5);
    mf_check("mflo", MD_MFLO, 32'h0000_000C);

`ifdef MDU_CANCEL_EN
    start_div_to_cnt3();
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    check_eq("cancel_busy", {63'd0, busy}, 64'd0);
    check_eq("cancel_hi", {32'd0, HI}, 64'd0);
    check_eq("cancel_lo", {32'd0, LO}, 64'h0000_000C);
    repeat (6) @(negedge clk);
    check_eq("cancel_late_lo", {32'd0, LO}, 64'h0000_000C);
`endif

    start_div_to_cnt3();
    reset = 1'b1;
    #1;
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_hi", {32'd0, HI}, 64'd0);
    check_eq("midrst_lo", {32'd0, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(MD_MULT, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0, 32'd42, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
